// File: rtl/dev_uart_ext.sv
// MMIO UART slot core: baud tick, TX/RX engines with FIFOs,
// runtime framing, sticky error flags and a level interrupt.
module dev_uart_ext #(
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int DVSR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
  localparam int PW = FIFO_DEPTH_BIT;
  localparam int CW = FIFO_DEPTH_BIT + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_e;

  logic unused;
  assign unused = ^{read, addr[4:3], wr_data};

  logic wr_en, wr_dvsr, wr_tx, wr_pop, wr_ctrl, wr_stat;
  assign wr_en   = cs && write;
  assign wr_dvsr = wr_en && addr[2:0] == 3'd1;
  assign wr_tx   = wr_en && addr[2:0] == 3'd2;
  assign wr_pop  = wr_en && addr[2:0] == 3'd3;
  assign wr_ctrl = wr_en && addr[2:0] == 3'd4;
  assign wr_stat = wr_en && addr[2:0] == 3'd5;

  logic [DVSR_W-1:0] dvsr_q, dvsr_d, cnt_q, cnt_d;
  logic [6:0] ctrl_q, ctrl_d;
  logic [3:0] flg_q, flg_d;
  logic irq_q, irq_d;
  logic tick;

  assign tick = cnt_q == dvsr_q;

  // TX FIFO
  logic [7:0] tx_mem [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic tx_empty, tx_full, tx_pop, tx_push_ok;
  logic [7:0] tx_head;

  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == CW'(DEPTH);
  assign tx_head  = tx_mem[tx_rp_q];
  assign tx_push_ok = wr_tx && (!tx_full || tx_pop);

  // RX FIFO
  logic [7:0] rx_mem [DEPTH];
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic rx_empty, rx_full, rx_push, rx_push_ok, rx_pop_ok;
  logic [7:0] rx_head, rx_byte;

  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == CW'(DEPTH);
  assign rx_head  = rx_mem[rx_rp_q];
  assign rx_pop_ok  = wr_pop && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);

  // TX engine state
  st_e tx_st_q, tx_st_d;
  logic [4:0] tx_tc_q, tx_tc_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [4:0] tx_cfg_q, tx_cfg_d;
  logic tx_par_q, tx_par_d, tx_q, tx_d, tx_busy;

  // RX engine state
  st_e rx_st_q, rx_st_d;
  logic [3:0] rx_tc_q, rx_tc_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [3:0] rx_cfg_q, rx_cfg_d;
  logic rx_s1_q, rx_s2_q;
  logic set_perr, set_ferr;

  assign tx_busy = tx_st_q != S_IDLE;
  assign rx_byte = rx_sr_q >> rx_cfg_q[1:0];

  always_comb begin
    dvsr_d = wr_dvsr ? wr_data[DVSR_W-1:0] : dvsr_q;
    cnt_d  = (wr_dvsr || tick) ? '0 : cnt_q + DVSR_W'(1);
    ctrl_d = wr_ctrl ? wr_data[6:0] : ctrl_q;

    tx_wp_d  = tx_push_ok ? tx_wp_q + PW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop ? tx_rp_q + PW'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push_ok && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
    if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);

    rx_wp_d  = rx_push_ok ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop_ok ? rx_rp_q + PW'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) rx_cnt_d = rx_cnt_q + CW'(1);
    if (!rx_push_ok && rx_pop_ok) rx_cnt_d = rx_cnt_q - CW'(1);

    // set wins over a same-cycle clear
    flg_d = ({wr_tx && !tx_push_ok, rx_push && !rx_push_ok,
              set_ferr, set_perr})
          | (flg_q & ~(wr_stat ? wr_data[7:4] : 4'b0));

    irq_d = (ctrl_q[5] && !rx_empty)
         || (ctrl_q[6] && tx_empty && !tx_busy);
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tc_d  = tx_tc_q;
    tx_bit_d = tx_bit_q;
    tx_sr_d  = tx_sr_q;
    tx_cfg_d = tx_cfg_q;
    tx_par_d = tx_par_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop   = 1'b1;
        tx_sr_d  = tx_head;
        tx_cfg_d = ctrl_q[4:0];
        tx_par_d = ^(tx_head & (8'hFF >> ctrl_q[1:0]))
                 ^ ctrl_q[3];
        tx_tc_d  = '0;
        tx_bit_d = '0;
        tx_d     = 1'b0;
        tx_st_d  = S_START;
      end
      S_START: if (tick) begin
        if (tx_tc_q == 5'd15) begin
          tx_tc_d = '0;
          tx_d    = tx_sr_q[0];
          tx_st_d = S_DATA;
        end else tx_tc_d = tx_tc_q + 5'd1;
      end
      S_DATA: if (tick) begin
        if (tx_tc_q == 5'd15) begin
          tx_tc_d = '0;
          if (tx_bit_q == 3'd7 - {1'b0, tx_cfg_q[1:0]}) begin
            tx_st_d = tx_cfg_q[2] ? S_PAR : S_STOP;
            tx_d    = tx_cfg_q[2] ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sr_d  = tx_sr_q >> 1;
            tx_d     = tx_sr_q[1];
          end
        end else tx_tc_d = tx_tc_q + 5'd1;
      end
      S_PAR: if (tick) begin
        if (tx_tc_q == 5'd15) begin
          tx_tc_d = '0;
          tx_d    = 1'b1;
          tx_st_d = S_STOP;
        end else tx_tc_d = tx_tc_q + 5'd1;
      end
      S_STOP: if (tick) begin
        if (tx_tc_q == (tx_cfg_q[4] ? 5'd31 : 5'd15))
          tx_st_d = S_IDLE;
        else tx_tc_d = tx_tc_q + 5'd1;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_tc_d  = rx_tc_q;
    rx_bit_d = rx_bit_q;
    rx_sr_d  = rx_sr_q;
    rx_cfg_d = rx_cfg_q;
    rx_push  = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    unique case (rx_st_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_cfg_d = ctrl_q[3:0];
        rx_tc_d  = '0;
        rx_bit_d = '0;
        rx_sr_d  = '0;
        rx_st_d  = S_START;
      end
      S_START: if (tick) begin
        if (rx_tc_q == 4'd7) begin
          rx_tc_d = '0;
          rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
        end else rx_tc_d = rx_tc_q + 4'd1;
      end
      S_DATA: if (tick) begin
        rx_tc_d = rx_tc_q + 4'd1;
        if (rx_tc_q == 4'd15) begin
          rx_sr_d = {rx_s2_q, rx_sr_q[7:1]};
          if (rx_bit_q == 3'd7 - {1'b0, rx_cfg_q[1:0]})
            rx_st_d = rx_cfg_q[2] ? S_PAR : S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      S_PAR: if (tick) begin
        rx_tc_d = rx_tc_q + 4'd1;
        if (rx_tc_q == 4'd15) begin
          set_perr = rx_s2_q != (^rx_byte ^ rx_cfg_q[3]);
          rx_st_d  = S_STOP;
        end
      end
      S_STOP: if (tick && rx_tc_q == 4'd15) begin
        rx_push  = 1'b1;
        set_ferr = !rx_s2_q;
        rx_st_d  = S_IDLE;
      end else if (tick) rx_tc_d = rx_tc_q + 4'd1;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      3'd0: rd_data = {22'b0, tx_full, rx_empty, rx_head};
      3'd1: rd_data = 32'(dvsr_q);
      3'd4: rd_data = {25'b0, ctrl_q};
      3'd5: rd_data = {23'b0, tx_busy, flg_q,
                       tx_full, tx_empty, rx_full, rx_empty};
      3'd6: rd_data = {16'(tx_cnt_q), 16'(rx_cnt_q)};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wp_q] <= wr_data[7:0];
    if (rx_push_ok) rx_mem[rx_wp_q] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q   <= '0;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      flg_q    <= '0;
      irq_q    <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_st_q  <= S_IDLE;
      tx_tc_q  <= '0;
      tx_bit_q <= '0;
      tx_sr_q  <= '0;
      tx_cfg_q <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_tc_q  <= '0;
      rx_bit_q <= '0;
      rx_sr_q  <= '0;
      rx_cfg_q <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
    end else begin
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      flg_q    <= flg_d;
      irq_q    <= irq_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_st_q  <= tx_st_d;
      tx_tc_q  <= tx_tc_d;
      tx_bit_q <= tx_bit_d;
      tx_sr_q  <= tx_sr_d;
      tx_cfg_q <= tx_cfg_d;
      tx_par_q <= tx_par_d;
      tx_q     <= tx_d;
      rx_st_q  <= rx_st_d;
      rx_tc_q  <= rx_tc_d;
      rx_bit_q <= rx_bit_d;
      rx_sr_q  <= rx_sr_d;
      rx_cfg_q <= rx_cfg_d;
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_dev_uart_ext.sv
// Scoreboard bench for dev_uart_ext: directed register reads,
// serial line probes and interrupt probes, checked by a monitor.
module tb_dev_uart_ext;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic tx, rx, irq;
  logic loop = 1'b0, rx_drv = 1'b1, probe = 1'b0;

  assign rx = loop ? tx : rx_drv;

  dev_uart_ext #(.FIFO_DEPTH_BIT(2), .DVSR_W(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read),
    .write(write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    logic [31:0] exp;
    string name;
  } chk_t;

  chk_t sbq[$];
  chk_t cur;
  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] act;

  always @(negedge clk) begin
    if (probe) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_mis++;
        $display("FAIL probe with empty scoreboard");
      end else begin
        cur = sbq.pop_front();
        case (cur.kind)
          0: act = rd_data;
          1: act = {31'b0, tx};
          default: act = {31'b0, irq};
        endcase
        if (act !== cur.exp) begin
          n_mis++;
          $display("FAIL %s: got %h expected %h",
                   cur.name, act, cur.exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = {2'b0, a};
    wr_data = d;
    cs = 1'b1;
    write = 1'b1;
    step();
    cs = 1'b0;
    write = 1'b0;
  endtask

  // kind 0: rd_data at a, 1: tx line, 2: irq
  task automatic chk(input int k, input logic [2:0] a,
                     input logic [31:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp = e;
    c.name = nm;
    sbq.push_back(c);
    addr = {2'b0, a};
    cs = (k == 0);
    read = (k == 0);
    probe = 1'b1;
    step();
    cs = 1'b0;
    read = 1'b0;
    probe = 1'b0;
  endtask

  task automatic wait_tx_fall(input string nm);
    int k = 0;
    while (tx && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: tx start not seen, got timeout", nm);
    end
  endtask

  // 64 clocks per bit at dvsr=3
  task automatic send_frame(input logic [7:0] d, input int nb,
                            input bit pe, input bit pb,
                            input int stop_lo);
    rx_drv = 1'b0;
    step(64);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      step(64);
    end
    if (pe) begin
      rx_drv = pb;
      step(64);
    end
    if (stop_lo > 0) begin
      rx_drv = 1'b0;
      step(stop_lo);
    end
    rx_drv = 1'b1;
    step(128);
  endtask

  logic [7:0] a5 = 8'hA5;
  logic [7:0] ob [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    step(3);
    reset = 1'b0;
    chk(0, 3'd5, 32'h005, "reset status");
    chk(1, 3'd0, 32'h1, "reset tx");
    chk(2, 3'd0, 32'h0, "reset irq");
    chk(0, 3'd6, 32'h0, "reset counts");
    chk(0, 3'd1, 32'h0, "reset dvsr");

    wr(3'd1, 32'd3);
    wr(3'd4, 32'h0);
    loop = 1'b1;
    wr(3'd2, 32'hA5);
    wait_tx_fall("a5 start");
    step(30);
    chk(1, 3'd0, 32'h0, "a5 start bit");
    for (int i = 0; i < 8; i++) begin
      step(63);
      chk(1, 3'd0, {31'b0, a5[i]}, $sformatf("a5 bit%0d", i));
    end
    step(63);
    chk(1, 3'd0, 32'h1, "a5 stop bit");
    step(200);
    chk(0, 3'd0, 32'h0A5, "a5 rx head");
    chk(0, 3'd5, 32'h004, "a5 status");
    wr(3'd3, 32'h0);
    chk(0, 3'd5, 32'h005, "a5 popped");

    wr(3'd4, 32'h0F);
    wr(3'd2, 32'h1F);
    wait_tx_fall("1f start");
    step(30);
    chk(1, 3'd0, 32'h0, "1f start bit");
    for (int i = 0; i < 5; i++) begin
      step(63);
      chk(1, 3'd0, 32'h1, $sformatf("1f bit%0d", i));
    end
    step(63);
    chk(1, 3'd0, 32'h0, "1f parity bit");
    step(63);
    chk(1, 3'd0, 32'h1, "1f stop bit");
    step(200);
    chk(0, 3'd0, 32'h01F, "1f rx head");
    chk(0, 3'd5, 32'h004, "1f no parity err");
    wr(3'd3, 32'h0);

    loop = 1'b0;
    send_frame(8'h1F, 5, 1'b1, 1'b1, 0);
    chk(0, 3'd5, 32'h014, "bad parity flag");
    wr(3'd5, 32'h10);
    chk(0, 3'd5, 32'h004, "parity w1c");
    chk(0, 3'd0, 32'h01F, "bad parity byte kept");
    wr(3'd3, 32'h0);

    wr(3'd4, 32'h0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 48);
    chk(0, 3'd5, 32'h024, "frame err flag");
    chk(0, 3'd6, 32'h1, "frame err one byte");
    chk(0, 3'd0, 32'h03C, "frame err byte kept");
    wr(3'd3, 32'h0);
    wr(3'd5, 32'h20);
    rx_drv = 1'b0;
    step(12);
    rx_drv = 1'b1;
    step(200);
    chk(0, 3'd6, 32'h0, "glitch no byte");
    chk(0, 3'd5, 32'h005, "glitch status");

    for (int i = 0; i < 5; i++)
      send_frame(ob[i], 8, 1'b0, 1'b0, 0);
    chk(0, 3'd5, 32'h046, "rx overrun status");
    chk(0, 3'd6, 32'h4, "rx count full");
    for (int i = 0; i < 4; i++) begin
      chk(0, 3'd0, {24'b0, ob[i]}, $sformatf("rx fifo %0d", i));
      wr(3'd3, 32'h0);
    end
    chk(0, 3'd5, 32'h045, "rx drained");
    wr(3'd5, 32'h40);
    chk(0, 3'd5, 32'h005, "rx ovr w1c");

    wr(3'd4, 32'h20);
    chk(2, 3'd0, 32'h0, "irq off when empty");
    send_frame(8'h5A, 8, 1'b0, 1'b0, 0);
    chk(2, 3'd0, 32'h1, "rx irq set");
    wr(3'd3, 32'h0);
    chk(2, 3'd0, 32'h1, "irq lag after pop");
    chk(2, 3'd0, 32'h0, "irq clear after pop");
    wr(3'd4, 32'h40);
    chk(2, 3'd0, 32'h0, "tx irq lag");
    chk(2, 3'd0, 32'h1, "tx irq set");
    wr(3'd4, 32'h0);

    wr(3'd1, 32'd1000);
    wr(3'd2, 32'h00);
    step(2);
    for (int i = 1; i <= 5; i++) wr(3'd2, i);
    chk(0, 3'd5, 32'h189, "tx overflow status");
    chk(0, 3'd6, 32'h00040000, "tx count full");
    chk(1, 3'd0, 32'h0, "tx mid frame");
    reset = 1'b1;
    step();
    chk(1, 3'd0, 32'h1, "tx after reset");
    reset = 1'b0;
    chk(0, 3'd5, 32'h005, "status after reset");
    chk(0, 3'd6, 32'h0, "counts after reset");
    chk(0, 3'd1, 32'h0, "dvsr after reset");
    chk(2, 3'd0, 32'h0, "irq after reset");
    step(2);

    if (sbq.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard leftover: got %0d expected 0",
               sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end
endmodule
